ft245_rx_read_ctrl: RTL

//   FPGA-side read controller for the FT245 host-to-device byte path. Watches the

---
 rtl/ft245_rx_read_ctrl.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/ft245_rx_read_ctrl.sv
// FT245 host-to-device read controller: strobes RD_N against a synchronised RXF_N
// and buffers received bytes in a show-ahead FIFO with a valid/ready interface.
module ft245_rx_read_ctrl #(
    parameter int RD_PULSE    = 4,
    parameter int PRECHARGE   = 3,
    parameter int RXF_TIMEOUT = 64,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        FT245_RXF_N,
    output logic        FT245_RD_N,
    input  logic [7:0]  FT245_DATA_IN,
    output logic [7:0]  RX_DATA,
    output logic        RX_VALID,
    input  logic        RX_READY,
    output logic        RX_FIFO_FULL,
    output logic [15:0] BYTE_COUNT,
    output logic        PROTOCOL_ERR
);

    localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W   = PTR_W + 1;
    localparam int TMR_A   = (RD_PULSE > PRECHARGE) ? RD_PULSE : PRECHARGE;
    localparam int TMR_MAX = (RXF_TIMEOUT > TMR_A) ? RXF_TIMEOUT : TMR_A;
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

    localparam logic [TMR_W-1:0] RD_LAST  = TMR_W'(RD_PULSE - 1);
    localparam logic [TMR_W-1:0] PRE_LAST = TMR_W'(PRECHARGE - 1);
    localparam logic [TMR_W-1:0] TO_LAST  = TMR_W'(RXF_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    typedef enum logic [3:0] {
        ST_IDLE          = 4'b0001,
        ST_ASSERT_RD     = 4'b0010,
        ST_WAIT_RXF_HIGH = 4'b0100,
        ST_PRECHARGE     = 4'b1000
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [TMR_W-1:0]  timer_r;
    logic [TMR_W-1:0]  timer_nxt_s;
    logic              rd_n_r;
    logic              rd_n_nxt_s;
    logic              push_s;
    logic              err_set_s;
    logic              err_r;
    logic              stale_r;
    logic              rxf_meta_r;
    logic              rxf_sync_r;
    logic [15:0]       byte_count_r;

    logic [7:0]        mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_nxt_s;
    logic [CNT_W-1:0]  count_r;
    logic [CNT_W-1:0]  count_nxt_s;
    logic              valid_r;
    logic              full_r;
    logic              pop_s;
    logic              room_s;
    logic [7:0]        rx_data_r;
    logic [7:0]        head_nxt_s;

    // Read-cycle sequencing: next state, phase timer, strobe level and FIFO push.
    always_comb begin
        state_nxt_s = state_r;
        timer_nxt_s = timer_r;
        rd_n_nxt_s  = rd_n_r;
        push_s      = 1'b0;
        err_set_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                // After a timeout, RXF_N must be seen high before another read starts.
                if (!rxf_sync_r && !stale_r && room_s) begin
                    state_nxt_s = ST_ASSERT_RD;
                    timer_nxt_s = {TMR_W{1'b0}};
                    rd_n_nxt_s  = 1'b0;
                end else begin
                    rd_n_nxt_s  = 1'b1;
                end
            end
            ST_ASSERT_RD: begin
                if (timer_r == RD_LAST) begin
                    push_s      = 1'b1;
                    rd_n_nxt_s  = 1'b1;
                    state_nxt_s = ST_WAIT_RXF_HIGH;
                    timer_nxt_s = {TMR_W{1'b0}};
                end else begin
                    rd_n_nxt_s  = 1'b0;
                    timer_nxt_s = timer_r + TMR_W'(1);
                end
            end
            ST_WAIT_RXF_HIGH: begin
                if (rxf_sync_r) begin
                    state_nxt_s = ST_PRECHARGE;
                    timer_nxt_s = {TMR_W{1'b0}};
                end else if (timer_r == TO_LAST) begin
                    err_set_s   = 1'b1;
                    state_nxt_s = ST_PRECHARGE;
                    timer_nxt_s = {TMR_W{1'b0}};
                end else begin
                    timer_nxt_s = timer_r + TMR_W'(1);
                end
            end
            ST_PRECHARGE: begin
                if (timer_r == PRE_LAST) begin
                    state_nxt_s = ST_IDLE;
                    timer_nxt_s = {TMR_W{1'b0}};
                end else begin
                    timer_nxt_s = timer_r + TMR_W'(1);
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                timer_nxt_s = {TMR_W{1'b0}};
                rd_n_nxt_s  = 1'b1;
            end
        endcase
    end

    // FIFO bookkeeping: pointer/count updates and the next show-ahead head byte.
    always_comb begin
        pop_s        = valid_r & RX_READY;
        room_s       = (count_r < CNT_FULL);
        rd_ptr_nxt_s = rd_ptr_r;
        count_nxt_s  = count_r;
        head_nxt_s   = rx_data_r;
        if (pop_s) begin
            rd_ptr_nxt_s = rd_ptr_r + PTR_W'(1);
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNT_W'(1);
            2'b01:   count_nxt_s = count_r - CNT_W'(1);
            default: count_nxt_s = count_r;
        endcase
        // A byte pushed into the slot that becomes the head bypasses the array.
        if (count_nxt_s == CNT_W'(0)) begin
            head_nxt_s = rx_data_r;
        end else if (push_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
            head_nxt_s = FT245_DATA_IN;
        end else begin
            head_nxt_s = mem_r[rd_ptr_nxt_s];
        end
    end

    // Control, synchroniser, counters and FIFO state registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r      <= ST_IDLE;
            timer_r      <= {TMR_W{1'b0}};
            rd_n_r       <= 1'b1;
            err_r        <= 1'b0;
            stale_r      <= 1'b0;
            rxf_meta_r   <= 1'b1;
            rxf_sync_r   <= 1'b1;
            byte_count_r <= 16'd0;
            wr_ptr_r     <= {PTR_W{1'b0}};
            rd_ptr_r     <= {PTR_W{1'b0}};
            count_r      <= {CNT_W{1'b0}};
            valid_r      <= 1'b0;
            full_r       <= 1'b0;
            rx_data_r    <= 8'h00;
        end else begin
            state_r    <= state_nxt_s;
            timer_r    <= timer_nxt_s;
            rd_n_r     <= rd_n_nxt_s;
            rxf_meta_r <= FT245_RXF_N;
            rxf_sync_r <= rxf_meta_r;
            if (err_set_s) begin
                err_r <= 1'b1;
            end
            if (err_set_s) begin
                stale_r <= 1'b1;
            end else if (rxf_sync_r) begin
                stale_r <= 1'b0;
            end
            if (push_s) begin
                byte_count_r <= byte_count_r + 16'd1;
                wr_ptr_r     <= wr_ptr_r + PTR_W'(1);
            end
            rd_ptr_r  <= rd_ptr_nxt_s;
            count_r   <= count_nxt_s;
            valid_r   <= (count_nxt_s != CNT_W'(0));
            full_r    <= (count_nxt_s == CNT_FULL);
            rx_data_r <= head_nxt_s;
        end
    end

    // FIFO storage array.
    always_ff @(posedge CLK) begin
        if (push_s && !RST) begin
            mem_r[wr_ptr_r] <= FT245_DATA_IN;
        end
    end

    assign FT245_RD_N   = rd_n_r;
    assign RX_DATA      = rx_data_r;
    assign RX_VALID     = valid_r;
    assign RX_FIFO_FULL = full_r;
    assign BYTE_COUNT   = byte_count_r;
    assign PROTOCOL_ERR = err_r;

endmodule
